// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the digit-serial BCD datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    COMP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic digit_bad(input bcd_digit_t d);
    return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_addsub.sv
// ============================================================================
// Module      : bcd_digit_addsub
// Description : Single BCD digit adder/subtractor with decimal carry/borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  input  logic       sub,
  output bcd_digit_t d,
  output logic       cout
);

  logic [BCD_DIGIT_W:0] w_sum;

  // Subtract range is -10..9, so the top bit of w_sum doubles as the sign.
  always_comb begin
    w_sum = '0;
    d     = '0;
    cout  = 1'b0;
    if (sub) begin
      w_sum = {1'b0, a} - {1'b0, b} - {{BCD_DIGIT_W{1'b0}}, cin};
      if (w_sum[BCD_DIGIT_W]) begin
        d    = BCD_DIGIT_W'(w_sum + 5'd10);
        cout = 1'b1;
      end else begin
        d = w_sum[BCD_DIGIT_W-1:0];
      end
    end else begin
      w_sum = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
      if (w_sum > 5'(BCD_MAX_DIGIT)) begin
        d    = BCD_DIGIT_W'(w_sum - 5'd10);
        cout = 1'b1;
      end else begin
        d = w_sum[BCD_DIGIT_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_subtractor.sv
// ============================================================================
// Module      : bcd_serial_subtractor
// Description : Digit-serial signed-magnitude BCD subtractor R = A - B.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        a_sign,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a_mag,
  input  logic                        b_sign,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b_mag,
  output logic                        busy,
  output logic                        done,
  output logic                        r_sign,
  output logic [BCD_DIGIT_W*DIGITS-1:0] r_mag,
  output logic                        ovf,
  output logic                        invalid
);

  localparam int c_mag_w = BCD_DIGIT_W * DIGITS;
  localparam int c_cnt_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(DIGITS - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_mag_w-1:0]   r_a_sh;
  logic [c_mag_w-1:0]   r_b_sh;
  logic [c_mag_w-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_carry;
  logic                 r_a_sign;
  logic                 r_add;
  logic                 r_neg;
  logic                 r_inv;

  logic [2*DIGITS-1:0]  w_nib_bad;
  logic                 w_any_bad;
  logic                 w_last;
  bcd_digit_t           w_cell_a;
  bcd_digit_t           w_cell_b;
  bcd_digit_t           w_cell_d;
  logic                 w_cell_sub;
  logic                 w_cell_cout;

  for (genvar i = 0; i < DIGITS; i++) begin : g_chk
    assign w_nib_bad[2*i]   = digit_bad(a_mag[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
    assign w_nib_bad[2*i+1] = digit_bad(b_mag[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
  end

  assign w_any_bad = |w_nib_bad;
  assign w_last    = (r_cnt == c_last);

  // The complement pass reuses the cell as 0 - R, reading back the result register.
  always_comb begin
    w_cell_a   = r_a_sh[BCD_DIGIT_W-1:0];
    w_cell_b   = r_b_sh[BCD_DIGIT_W-1:0];
    w_cell_sub = ~r_add;
    if (r_state == COMP) begin
      w_cell_a   = '0;
      w_cell_b   = r_acc[BCD_DIGIT_W-1:0];
      w_cell_sub = 1'b1;
    end
  end

  bcd_digit_addsub u_cell (
    .a    (w_cell_a),
    .b    (w_cell_b),
    .cin  (r_carry),
    .sub  (w_cell_sub),
    .d    (w_cell_d),
    .cout (w_cell_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = w_any_bad ? DONE : DIGIT;
      DIGIT:   if (w_last) w_state_nxt = (!r_add && w_cell_cout) ? COMP : DONE;
      COMP:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a_sign <= 1'b0;
      r_add    <= 1'b0;
      r_neg    <= 1'b0;
      r_inv    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      r_sign   <= 1'b0;
      r_mag    <= '0;
      ovf      <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            r_a_sh   <= a_mag;
            r_b_sh   <= b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_a_sign <= a_sign;
            r_add    <= a_sign ^ b_sign;
            r_neg    <= 1'b0;
            r_inv    <= w_any_bad;
          end
        end
        DIGIT: begin
          r_acc  <= c_mag_w'({w_cell_d, r_acc} >> BCD_DIGIT_W);
          r_a_sh <= r_a_sh >> BCD_DIGIT_W;
          r_b_sh <= r_b_sh >> BCD_DIGIT_W;
          r_cnt  <= w_last ? '0 : r_cnt + c_cnt_one;
          // A final borrow means |A| < |B|: clear it so the complement pass starts clean.
          if (w_last && !r_add && w_cell_cout) begin
            r_carry <= 1'b0;
            r_neg   <= 1'b1;
          end else begin
            r_carry <= w_cell_cout;
          end
        end
        COMP: begin
          r_acc   <= c_mag_w'({w_cell_d, r_acc} >> BCD_DIGIT_W);
          r_cnt   <= w_last ? '0 : r_cnt + c_cnt_one;
          r_carry <= w_cell_cout;
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (r_inv) begin
            r_mag   <= '0;
            r_sign  <= 1'b0;
            ovf     <= 1'b0;
            invalid <= 1'b1;
          end else begin
            r_mag   <= r_acc;
            r_sign  <= (r_acc != '0) && (r_neg ? ~r_a_sign : r_a_sign);
            ovf     <= r_add & r_carry;
            invalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_subtractor.sv
// ============================================================================
// Module      : tb_bcd_serial_subtractor
// Description : Directed self-checking bench for bcd_serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        a_sign = 1'b0;
  logic        b_sign = 1'b0;
  logic [11:0] a_mag = '0;
  logic [11:0] b_mag = '0;
  logic        busy;
  logic        done;
  logic        r_sign;
  logic [11:0] r_mag;
  logic        ovf;
  logic        invalid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_serial_subtractor #(.DIGITS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_sign  (a_sign),
    .a_mag   (a_mag),
    .b_sign  (b_sign),
    .b_mag   (b_mag),
    .busy    (busy),
    .done    (done),
    .r_sign  (r_sign),
    .r_mag   (r_mag),
    .ovf     (ovf),
    .invalid (invalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge 0 is the start edge; operands are scrambled right after it.
  task automatic do_op(input string tag,
                       input logic as, input logic [11:0] am,
                       input logic bs, input logic [11:0] bm,
                       input logic es, input logic [11:0] em,
                       input logic eo, input logic ei,
                       input int elat, input bit poke);
    int lat;
    lat = 0;
    @(negedge clk);
    a_sign = as; a_mag = am; b_sign = bs; b_mag = bm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_sign = ~as; a_mag = 12'h999; b_mag = 12'h888;
    chk({tag, " busy_e0"}, busy, 1);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (poke) start = (k <= 2);
      @(posedge clk); #1;
      if (done === 1'b1) lat = k;
      else chk({tag, " busy_mid"}, busy, 1);
    end
    start = 1'b0;
    chk({tag, " done_edge"}, lat, elat);
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " r_sign"}, r_sign, es);
    chk({tag, " r_mag"}, r_mag, em);
    chk({tag, " ovf"}, ovf, eo);
    chk({tag, " invalid"}, invalid, ei);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, done, 0);
      chk({tag, " busy_after"}, busy, 0);
      chk({tag, " hold_mag"}, r_mag, em);
      chk({tag, " hold_sign"}, r_sign, es);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst r_sign", r_sign, 0);
    chk("rst r_mag", r_mag, 0);
    chk("rst ovf", ovf, 0);
    chk("rst invalid", invalid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("p123_m_p045", 0, 12'h123, 0, 12'h045, 0, 12'h078, 0, 0, 4, 0);
    do_op("p045_m_p123", 0, 12'h045, 0, 12'h123, 1, 12'h078, 0, 0, 7, 0);
    do_op("p999_m_n001", 0, 12'h999, 1, 12'h001, 0, 12'h000, 1, 0, 4, 0);
    do_op("n250_m_n250", 1, 12'h250, 1, 12'h250, 0, 12'h000, 0, 0, 4, 0);
    do_op("bad_nibble",  0, 12'h1A3, 0, 12'h045, 0, 12'h000, 0, 1, 1, 0);
    do_op("p500_m_p200", 0, 12'h500, 0, 12'h200, 0, 12'h300, 0, 0, 4, 0);
    do_op("n100_m_p023", 1, 12'h100, 0, 12'h023, 1, 12'h123, 0, 0, 4, 0);
    do_op("n023_m_n100", 1, 12'h023, 1, 12'h100, 0, 12'h077, 0, 0, 7, 0);
    do_op("start_poke",  0, 12'h123, 0, 12'h045, 0, 12'h078, 0, 0, 4, 1);

    // Asynchronous reset in the middle of a borrow-path operation.
    @(negedge clk);
    a_sign = 0; a_mag = 12'h045; b_sign = 0; b_mag = 12'h123; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst r_sign", r_sign, 0);
    chk("midrst r_mag", r_mag, 0);
    chk("midrst ovf", ovf, 0);
    chk("midrst invalid", invalid, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("midrst no_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("postrst idle_done", done, 0);
      chk("postrst idle_busy", busy, 0);
    end

    do_op("after_reset", 0, 12'h045, 0, 12'h123, 1, 12'h078, 0, 0, 7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
